// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler
//   In-order DRAM command scheduler. Parsed CPU requests are buffered in a
//   FIFO; the head request is decoded into bank group / bank / row / column
//   and serviced with PRE/ACT/RD/WR commands under fixed timing, then retired
//   with a req_done strobe. An open-row table covers all 16 banks.
//
// Build option:
//   DRAM_CLOSE_PAGE_EN  defined   -> close-page policy: every retired request
//                                    is followed by a PRE to its bank, then a
//                                    T_RP wait before the next head is looked at.
//                       undefined -> open-page policy: a bank stays open until
//                                    a row conflict forces a PRE.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   op_ready_s            strobe: {opcode, address} carries a new request
//   opcode, address       request type (READ/WRITE/IFETCH) and byte address
//   queue_full            FIFO holds QUEUE_DEPTH entries
//   overflow              sticky: a request arrived while full and was dropped
//   occupancy             FIFO entries held
//   cmd_valid, cmd        strobe + command code (NONE/ACT/PRE/RD/WR)
//   cmd_bg .. cmd_col     command target; hold their value while cmd_valid=0
//   req_done              strobe: head request retired and popped
//   dbg_state             current scheduler FSM state
//
// Handshakes: there is no backpressure anywhere. op_ready_s is a one-cycle
// strobe sampled on the rising edge and accepted only when queue_full is low
// at that edge; cmd_valid and req_done are one-cycle registered strobes that
// the downstream stage must consume in the cycle they are presented.

package dram_cmd_scheduler_pkg;
    localparam int ADDRESS_WIDTH = 33;

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_IFETCH = 2'd2
    } parsed_op_t;

    localparam logic [2:0] CMD_NONE = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_PRE  = 3'd2;
    localparam logic [2:0] CMD_RD   = 3'd3;
    localparam logic [2:0] CMD_WR   = 3'd4;
endpackage

module dram_cmd_scheduler
    import dram_cmd_scheduler_pkg::*;
#(
    parameter int QUEUE_DEPTH = 16,
    parameter int T_RCD       = 24,
    parameter int T_RP        = 24,
    parameter int T_CL        = 24,
    parameter int T_CWL       = 20,
    parameter int T_BURST     = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             op_ready_s,
    input  parsed_op_t                       opcode,
    input  logic [ADDRESS_WIDTH-1:0]         address,
    output logic                             queue_full,
    output logic                             overflow,
    output logic [$clog2(QUEUE_DEPTH):0]     occupancy,
    output logic                             cmd_valid,
    output logic [2:0]                       cmd,
    output logic [1:0]                       cmd_bg,
    output logic [1:0]                       cmd_bank,
    output logic [14:0]                      cmd_row,
    output logic [10:0]                      cmd_col,
    output logic                             req_done,
    output logic [2:0]                       dbg_state
);

    localparam int PTR_W    = $clog2(QUEUE_DEPTH);
    localparam int OCC_W    = PTR_W + 1;
    localparam int RD_LAT   = T_CL + T_BURST;
    localparam int WR_LAT   = T_CWL + T_BURST;
    localparam int DATA_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CMD_MAX  = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int T_MAX    = (DATA_MAX > CMD_MAX) ? DATA_MAX : CMD_MAX;
    localparam int TW       = $clog2(T_MAX + 1);

    // Timers are loaded with (delay - 1): the follow-on command is issued on
    // the edge after the timer reads zero, i.e. exactly 'delay' edges later.
    localparam logic [TW-1:0] LD_RCD = TW'(T_RCD - 1);
    localparam logic [TW-1:0] LD_RP  = TW'(T_RP - 1);
    localparam logic [TW-1:0] LD_RD  = TW'(RD_LAT - 1);
    localparam logic [TW-1:0] LD_WR  = TW'(WR_LAT - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRE_WAIT   = 3'd1,
        ACT_WAIT   = 3'd2,
        DATA_WAIT  = 3'd3
`ifdef DRAM_CLOSE_PAGE_EN
        ,
        CLOSE_PRE  = 3'd4,
        CLOSE_WAIT = 3'd5
`endif
    } state_t;

    // Byte-offset bits never reach the DRAM; only address[32:3] is stored.
    typedef struct packed {
        parsed_op_t                 op;
        logic [ADDRESS_WIDTH-4:0]   line;
    } req_t;

    logic unused_addr_bits;
    assign unused_addr_bits = ^address[2:0];

    // ---------------- request FIFO ----------------
    req_t             mem_q [QUEUE_DEPTH];
    req_t             mem_d [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;
    logic             push, pop;

    // Full is taken from the registered flag, so a retire on the same edge
    // cannot make room for that edge's enqueue.
    assign push = op_ready_s && !full_q;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        occ_d      = occ_q + OCC_W'(push) - OCC_W'(pop);
        full_d     = (occ_d == OCC_W'(QUEUE_DEPTH));
        overflow_d = overflow_q || (op_ready_s && full_q);
        if (push) begin
            mem_d[wr_ptr_q] = '{op: opcode, line: address[ADDRESS_WIDTH-1:3]};
        end
    end

    // ---------------- head decode ----------------
    req_t        head;
    logic [14:0] head_row;
    logic [1:0]  head_bg, head_bank;
    logic [10:0] head_col;
    logic [3:0]  head_idx;
    logic        head_wr;

    assign head      = mem_q[rd_ptr_q];
    assign head_row  = head.line[29:15];
    assign head_bank = head.line[6:5];
    assign head_bg   = head.line[4:3];
    assign head_col  = {head.line[14:7], head.line[2:0]};
    assign head_idx  = {head_bg, head_bank};
    assign head_wr   = (head.op == OP_WRITE);   // IFETCH goes out as a read

    // ---------------- scheduler FSM ----------------
    state_t       state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]  open_q, open_d;
    logic [14:0]  row_q [16];
    logic [14:0]  row_d [16];
    logic         cmd_valid_q, cmd_valid_d, req_done_q, req_done_d;
    logic [2:0]   cmd_q, cmd_d, issue;
    logic [1:0]   cmd_bg_q, cmd_bg_d, cmd_bank_q, cmd_bank_d;
    logic [14:0]  cmd_row_q, cmd_row_d;
    logic [10:0]  cmd_col_q, cmd_col_d;
    logic         timer_expired;
`ifdef DRAM_CLOSE_PAGE_EN
    logic [3:0]   close_idx_q, close_idx_d;
`endif

    assign timer_expired = (timer_q == '0);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_expired ? '0 : timer_q - 1'b1;
        open_d     = open_q;
        row_d      = row_q;
        pop        = 1'b0;
        req_done_d = 1'b0;
        issue      = CMD_NONE;
`ifdef DRAM_CLOSE_PAGE_EN
        close_idx_d = close_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (occ_q != '0) begin
                    if (!open_q[head_idx]) begin
                        issue            = CMD_ACT;
                        open_d[head_idx] = 1'b1;
                        row_d[head_idx]  = head_row;
                        timer_d          = LD_RCD;
                        state_d          = ACT_WAIT;
                    end else if (row_q[head_idx] == head_row) begin
                        issue   = head_wr ? CMD_WR : CMD_RD;
                        timer_d = head_wr ? LD_WR : LD_RD;
                        state_d = DATA_WAIT;
                    end else begin
                        issue            = CMD_PRE;
                        open_d[head_idx] = 1'b0;
                        timer_d          = LD_RP;
                        state_d          = PRE_WAIT;
                    end
                end
            end
            PRE_WAIT: begin
                if (timer_expired) begin
                    issue            = CMD_ACT;
                    open_d[head_idx] = 1'b1;
                    row_d[head_idx]  = head_row;
                    timer_d          = LD_RCD;
                    state_d          = ACT_WAIT;
                end
            end
            ACT_WAIT: begin
                if (timer_expired) begin
                    issue   = head_wr ? CMD_WR : CMD_RD;
                    timer_d = head_wr ? LD_WR : LD_RD;
                    state_d = DATA_WAIT;
                end
            end
            DATA_WAIT: begin
                if (timer_expired) begin
                    req_done_d = 1'b1;
                    pop        = 1'b1;
`ifdef DRAM_CLOSE_PAGE_EN
                    // The head is popped on this edge; remember its bank.
                    close_idx_d = head_idx;
                    state_d     = CLOSE_PRE;
`else
                    state_d    = IDLE;
`endif
                end
            end
`ifdef DRAM_CLOSE_PAGE_EN
            CLOSE_PRE: begin
                issue               = CMD_PRE;
                open_d[close_idx_q] = 1'b0;
                timer_d             = LD_RP;
                state_d             = CLOSE_WAIT;
            end
            CLOSE_WAIT: begin
                if (timer_expired) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        cmd_valid_d = (issue != CMD_NONE);
        cmd_d       = issue;
        cmd_bg_d    = cmd_bg_q;
        cmd_bank_d  = cmd_bank_q;
        cmd_row_d   = cmd_row_q;
        cmd_col_d   = cmd_col_q;
        if (issue != CMD_NONE) begin
            cmd_bg_d   = head_bg;
            cmd_bank_d = head_bank;
            cmd_row_d  = head_row;
            cmd_col_d  = head_col;
`ifdef DRAM_CLOSE_PAGE_EN
            if (state_q == CLOSE_PRE) begin
                cmd_bg_d   = close_idx_q[3:2];
                cmd_bank_d = close_idx_q[1:0];
                cmd_row_d  = row_q[close_idx_q];
                cmd_col_d  = cmd_col_q;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            state_q     <= IDLE;
            timer_q     <= '0;
            open_q      <= '0;
            row_q       <= '{default: '0};
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NONE;
            cmd_bg_q    <= '0;
            cmd_bank_q  <= '0;
            cmd_row_q   <= '0;
            cmd_col_q   <= '0;
            req_done_q  <= 1'b0;
`ifdef DRAM_CLOSE_PAGE_EN
            close_idx_q <= '0;
`endif
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            open_q      <= open_d;
            row_q       <= row_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            cmd_bg_q    <= cmd_bg_d;
            cmd_bank_q  <= cmd_bank_d;
            cmd_row_q   <= cmd_row_d;
            cmd_col_q   <= cmd_col_d;
            req_done_q  <= req_done_d;
`ifdef DRAM_CLOSE_PAGE_EN
            close_idx_q <= close_idx_d;
`endif
        end
    end

    assign queue_full = full_q;
    assign overflow   = overflow_q;
    assign occupancy  = occ_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd        = cmd_q;
    assign cmd_bg     = cmd_bg_q;
    assign cmd_bank   = cmd_bank_q;
    assign cmd_row    = cmd_row_q;
    assign cmd_col    = cmd_col_q;
    assign req_done   = req_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Bench for dram_cmd_scheduler (default open-page build). Directed requests
// are driven on the falling edge; for each accepted request the expected
// command/retire events, stamped with the edge number they must appear on,
// are pushed into exp_q. A monitor on the falling edge pops and compares
// every cmd_valid / req_done it sees.
module tb_dram_cmd_scheduler;
    import dram_cmd_scheduler_pkg::*;

    localparam int EW = 66;  // {edge[31:0], done, cmd[2:0], bg, bank, row[14:0], col[10:0]}

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_ready_s = 1'b0;
    parsed_op_t  opcode = OP_READ;
    logic [32:0] address = '0;
    logic        queue_full, overflow, cmd_valid, req_done;
    logic [4:0]  occupancy;
    logic [2:0]  cmd, dbg_state;
    logic [1:0]  cmd_bg, cmd_bank;
    logic [14:0] cmd_row;
    logic [10:0] cmd_col;

    dram_cmd_scheduler dut (
        .clk(clk), .rst_n(rst_n), .op_ready_s(op_ready_s), .opcode(opcode),
        .address(address), .queue_full(queue_full), .overflow(overflow),
        .occupancy(occupancy), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
        .cmd_col(cmd_col), .req_done(req_done), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;   // number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [EW-1:0] mk_ev(input int unsigned e, input logic done,
                                            input logic [2:0] k, input logic [1:0] bg,
                                            input logic [1:0] bank, input logic [14:0] row,
                                            input logic [10:0] col);
        return {e, done, k, bg, bank, row, col};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0d, required %0d", name, act, req);
        end
    endtask

    task automatic compare_ev(input logic [EW-1:0] act);
        logic [EW-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: actual %h at edge %0d, required none", act, act[65:34]);
        end else begin
            e = exp_q.pop_front();
            if (e !== act) begin
                errors++;
                $display("FAIL event: actual %h (edge %0d done %0d cmd %0d), required %h (edge %0d done %0d cmd %0d)",
                         act, act[65:34], act[33], act[32:30], e, e[65:34], e[33], e[32:30]);
            end
        end
    endtask

    // Monitor: row is only meaningful on ACT, column only on RD/WR.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_done) compare_ev(mk_ev(cyc, 1'b1, 3'd0, 2'd0, 2'd0, 15'd0, 11'd0));
            if (cmd_valid) begin
                compare_ev(mk_ev(cyc, 1'b0, cmd, cmd_bg, cmd_bank,
                                 (cmd == 3'd1) ? cmd_row : 15'd0,
                                 (cmd == 3'd3 || cmd == 3'd4) ? cmd_col : 11'd0));
            end else begin
                check("idle_cmd_none", 32'(cmd), 32'd0);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [15:0]  m_open = '0;
    logic [14:0]  m_row [16];
    int unsigned  m_last = 0;
    int unsigned  m_done[$];

    task automatic model_reset();
        m_open = '0;
        m_last = 0;
        m_done.delete();
        exp_q.delete();
    endtask

    // Drive one strobe and predict its command sequence.
    task automatic send(input parsed_op_t op, input logic [32:0] a);
        int unsigned e, s, d, lat;
        int live;
        logic [3:0]  idx;
        logic [14:0] row;
        logic [10:0] col;
        logic [1:0]  bg, bank;
        logic [2:0]  rw;
        e = cyc + 1;
        op_ready_s = 1'b1;
        opcode = op;
        address = a;
        live = 0;
        foreach (m_done[i]) if (m_done[i] >= e) live++;
        if (live < 16) begin
            row  = a[32:18];
            bank = a[9:8];
            bg   = a[7:6];
            col  = {a[17:10], a[5:3]};
            idx  = {bg, bank};
            rw   = (op == OP_WRITE) ? 3'd4 : 3'd3;
            lat  = (op == OP_WRITE) ? 24 : 28;
            s    = ((e > m_last) ? e : m_last) + 1;
            if (m_open[idx] && m_row[idx] == row) begin
                exp_q.push_back(mk_ev(s, 1'b0, rw, bg, bank, 15'd0, col));
                d = s + lat;
            end else if (!m_open[idx]) begin
                exp_q.push_back(mk_ev(s, 1'b0, 3'd1, bg, bank, row, 11'd0));
                exp_q.push_back(mk_ev(s + 24, 1'b0, rw, bg, bank, 15'd0, col));
                d = s + 24 + lat;
            end else begin
                exp_q.push_back(mk_ev(s, 1'b0, 3'd2, bg, bank, 15'd0, 11'd0));
                exp_q.push_back(mk_ev(s + 24, 1'b0, 3'd1, bg, bank, row, 11'd0));
                exp_q.push_back(mk_ev(s + 48, 1'b0, rw, bg, bank, 15'd0, col));
                d = s + 48 + lat;
            end
            m_open[idx] = 1'b1;
            m_row[idx]  = row;
            exp_q.push_back(mk_ev(d, 1'b1, 3'd0, 2'd0, 2'd0, 15'd0, 11'd0));
            m_last = d;
            m_done.push_back(d);
        end
        @(negedge clk);
        op_ready_s = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d events pending after %0d cycles, required 0", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    // Overflow burst: first entry opens bank 1 and blocks in ACT_WAIT.
    parsed_op_t  tbl_op [17] = '{OP_READ, OP_READ, OP_WRITE, OP_IFETCH, OP_READ, OP_WRITE,
                                  OP_READ, OP_READ, OP_READ, OP_WRITE, OP_READ, OP_READ,
                                  OP_IFETCH, OP_WRITE, OP_READ, OP_WRITE, OP_READ};
    logic [32:0] tbl_addr [17] = '{33'h0_0000_0100, 33'h0_0000_0108, 33'h0_0000_0110,
                                   33'h0_0008_0040, 33'h0_0008_0000, 33'h0_000C_0000,
                                   33'h0_0004_0100, 33'h1_FFFF_FCB8, 33'h1_FFFF_FCB8,
                                   33'h0_0000_00C0, 33'h0_0000_0300, 33'h0_0004_0300,
                                   33'h0_0000_0108, 33'h0_0000_0100, 33'h0_000C_0000,
                                   33'h0_000C_0007, 33'h0_0000_0200};

    // ---------------- directed sequence ----------------
    initial begin
        // Reset held 3 cycles with the strobe toggling.
        repeat (3) begin
            op_ready_s = ~op_ready_s;
            address = 33'($urandom_range(0, 32'h7FFF_FFFF));
            @(negedge clk);
        end
        check("rst_queue_full", 32'(queue_full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_cmd_bg", 32'(cmd_bg), 32'd0);
        check("rst_cmd_bank", 32'(cmd_bank), 32'd0);
        check("rst_cmd_row", 32'(cmd_row), 32'd0);
        check("rst_cmd_col", 32'(cmd_col), 32'd0);
        check("rst_req_done", 32'(req_done), 32'd0);
        op_ready_s = 1'b0;
        rst_n = 1'b1;

        // Closed bank: ACT, RD +24, done +52.
        send(OP_READ, 33'h0_0004_0000);
        check("occ_after_enqueue", 32'(occupancy), 32'd1);
        wait_drain("drain_read_miss", 200);
        check("occ_after_read_miss", 32'(occupancy), 32'd0);

        // Row hit: RD only, done +28.
        send(OP_READ, 33'h0_0004_0008);
        wait_drain("drain_read_hit", 200);

        // Row conflict: PRE, ACT +24, WR +48, done +72.
        send(OP_WRITE, 33'h0_0008_0000);
        wait_drain("drain_write_conflict", 200);
        check("occ_after_conflict", 32'(occupancy), 32'd0);

        // 17 back-to-back strobes; the last one is dropped.
        for (int i = 0; i < 17; i++) send(tbl_op[i], tbl_addr[i]);
        check("burst_occupancy", 32'(occupancy), 32'd16);
        check("burst_queue_full", 32'(queue_full), 32'd1);
        check("burst_overflow", 32'(overflow), 32'd1);
        wait_drain("drain_burst", 3000);
        check("burst_overflow_sticky", 32'(overflow), 32'd1);
        check("burst_full_cleared", 32'(queue_full), 32'd0);
        check("burst_occ_empty", 32'(occupancy), 32'd0);

        // Reset during DATA_WAIT on bank 15: no retire, bank closed afterwards.
        send(OP_READ, 33'h0_0000_03C0);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("midrst_occupancy", 32'(occupancy), 32'd0);
        check("midrst_req_done", 32'(req_done), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("postrst_occupancy", 32'(occupancy), 32'd0);
        send(OP_READ, 33'h0_0000_03C0);
        wait_drain("drain_after_reset", 200);
        check("final_occupancy", 32'(occupancy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_cmd_scheduler.md
# dram_cmd_scheduler

In-order DRAM command scheduler sitting between the trace parser and the DRAM command output/logging stage. It buffers parsed CPU requests in a FIFO and decodes each head request into bank group, bank, row and column. It tracks the open row of all 16 banks and sequences PRE/ACT/RD/WR commands under fixed timing constraints. One request is serviced at a time; each is retired with a completion strobe.

## Interface
- QUEUE_DEPTH, 16, request FIFO entries (power of 2)
- T_RCD, 24, clk cycles from ACT to RD/WR
- T_RP, 24, clk cycles from PRE to ACT
- T_CL, 24, clk cycles from RD to data
- T_CWL, 20, clk cycles from WR to data
- T_BURST, 4, clk cycles of data burst

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- op_ready_s  in  1  single-cycle strobe: new request on opcode/address
- opcode  in  parsed_op_t  0 READ, 1 WRITE, 2 IFETCH
- address  in  ADDRESS_WIDTH (33)  request byte address
- queue_full  out  1  occupancy == QUEUE_DEPTH
- overflow  out  1  sticky: a request was dropped
- occupancy  out  $clog2(QUEUE_DEPTH)+1  entries held
- cmd_valid  out  1  single-cycle strobe: command on cmd_* this cycle
- cmd  out  3  0 NONE, 1 ACT, 2 PRE, 3 RD, 4 WR
- cmd_bg  out  2  bank group
- cmd_bank  out  2  bank
- cmd_row  out  15  row
- cmd_col  out  11  column
- req_done  out  1  single-cycle strobe: head request retired

## Operation
- Address map: row = address[32:18], bank = address[9:8], bg = address[7:6], col = {address[17:10], address[5:3]}; address[2:0] ignored.
- Enqueue: op_ready_s && !queue_full writes {opcode, address} at the tail. op_ready_s while full: request dropped, overflow set until reset. A retire in the same cycle does not free a slot for that cycle's enqueue.
- IFETCH is scheduled identically to READ.
- Bank table: 16 entries of {open, row[14:0]}, indexed {bg, bank}.
- FSM states: IDLE, PRE_WAIT, ACT_WAIT, DATA_WAIT.
  - IDLE, queue empty: stay.
  - IDLE, head bank open and row matches: issue RD/WR, go to DATA_WAIT.
  - IDLE, head bank closed: issue ACT, mark the bank open with the head row, go to ACT_WAIT.
  - IDLE, head bank open and row differs: issue PRE, mark the bank closed, go to PRE_WAIT.
  - PRE_WAIT: when the timer expires, issue ACT and go to ACT_WAIT.
  - ACT_WAIT: when the timer expires, issue RD/WR and go to DATA_WAIT.
  - DATA_WAIT: when the timer expires, pulse req_done, pop the head and return to IDLE.
- Timer: loaded on each command issue; widths sized from the largest parameter sum.
- Reset: flush the queue, close all banks, FSM to IDLE.
  - Outputs at reset: all zero (queue_full 0, overflow 0, occupancy 0, cmd_valid 0, cmd NONE, cmd_* 0, req_done 0).
  - Reset mid-operation discards the in-flight request; no req_done is issued.
- When cmd_valid is 0: cmd = NONE and cmd_* hold their last values.

## Timing
- All outputs are registered.
- Enqueue at edge E: occupancy updates at E. The head is evaluated in IDLE during the following cycle; its first command appears at E+1 edge.
- Command spacing, command at edge t:
  - PRE at t → ACT at t+T_RP.
  - ACT at t → RD/WR at t+T_RCD.
  - RD at t → req_done at t+T_CL+T_BURST.
  - WR at t → req_done at t+T_CWL+T_BURST.
- The pop occurs on the req_done edge. The next head's first command comes no earlier than 1 cycle after req_done.
- At most one command per cycle; cmd_valid is never high for 2 consecutive cycles except across an IDLE evaluation.

## Configuration
- DRAM_CLOSE_PAGE_EN defined: after each DATA_WAIT expiry, the scheduler pulses req_done, issues PRE to that bank on the next edge and marks the bank closed. It then waits T_RP before returning to IDLE, so every request sees a closed bank (ACT→RD/WR only).
- Undefined: open-page policy as described in Operation; banks stay open until a row conflict.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with op_ready_s toggling → all outputs 0, occupancy 0, no cmd_valid.
- READ 0x0_0004_0000 to an idle scheduler → ACT (bg0, bank0, row 1) at t, RD (col 0) at t+24, req_done at t+52, occupancy back to 0.
- Second READ 0x0_0004_0008 after the above → RD (col 1) only, 1 cycle after entering IDLE, no ACT; req_done 28 cycles after RD.
- WRITE 0x0_0008_0000 (same bank, row 2) with row 1 open → PRE at t, ACT row 2 at t+24, WR at t+48, req_done at t+72.
- 17 back-to-back strobes while the first request is blocked in ACT_WAIT → occupancy 16, queue_full=1, 17th dropped, overflow=1 until reset; all 16 retire in order.
- Reset asserted during DATA_WAIT → no req_done, occupancy 0, and the next READ to the same bank issues ACT (bank closed).
